// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 butterfly datapath.
// Combinational helpers only; no latency or flow control of its own.
package fft_pkg;

  localparam int FFT_DW = 16;
  localparam int FFT_TW = 16;

  // Q1.15 twiddle values for +1 (closest representable) and -1.
  localparam logic [15:0] TW_ONE       = 16'h7FFF;
  localparam logic [15:0] TW_MINUS_ONE = 16'h8000;

  typedef struct packed {
    logic signed [FFT_DW-1:0] re;
    logic signed [FFT_DW-1:0] im;
  } cplx_t;

  // Clamp v to the signed range of a w-bit value; result stays sign-extended to 64 bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      sat_signed = hi;
    end else if (v < lo) begin
      sat_signed = lo;
    end else begin
      sat_signed = v;
    end
  endfunction

endpackage

// File: rtl/fft_cmult.sv
// Complex multiply W*B scaled back to data precision and clamped to DATA_WIDTH+1 bits.
// Latency 2 cycles (products, then scaled sums); every stage holds while en=0.
// FFT_BUTTERFLY_ROUND_EN selects round-half-up instead of truncation on the scale.
module fft_cmult
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH    = FFT_DW,
  parameter int TWIDDLE_WIDTH = FFT_TW,
  parameter int SIDE_WIDTH    = 2 * FFT_DW
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            en,
  input  logic                            in_vld,
  input  logic signed [DATA_WIDTH-1:0]    b_re,
  input  logic signed [DATA_WIDTH-1:0]    b_im,
  input  logic signed [TWIDDLE_WIDTH-1:0] w_re,
  input  logic signed [TWIDDLE_WIDTH-1:0] w_im,
  input  logic        [SIDE_WIDTH-1:0]    side_in,
  output logic                            s2_vld,
  output logic                            s3_vld,
  output logic signed [DATA_WIDTH:0]      wb_re,
  output logic signed [DATA_WIDTH:0]      wb_im,
  output logic        [SIDE_WIDTH-1:0]    side_out
);

  localparam int PW = DATA_WIDTH + TWIDDLE_WIDTH;

  logic signed [PW-1:0]   p_rr, p_ii, p_ri, p_ir;
  logic [SIDE_WIDTH-1:0]  side_s2;
  logic signed [63:0]     sum_re, sum_im, sc_re, sc_im;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s2_vld <= 1'b0;
      s3_vld <= 1'b0;
    end else if (en) begin
      s2_vld <= in_vld;
      s3_vld <= s2_vld;
    end
  end

  always_ff @(posedge clk_i) begin
    if (en) begin
      p_rr    <= PW'(b_re) * PW'(w_re);
      p_ii    <= PW'(b_im) * PW'(w_im);
      p_ri    <= PW'(b_re) * PW'(w_im);
      p_ir    <= PW'(b_im) * PW'(w_re);
      side_s2 <= side_in;
    end
  end

  // The 64-bit working width comfortably covers the PW+1 bit sums plus the rounding bias.
  always_comb begin
    sum_re = 64'(p_rr) - 64'(p_ii);
    sum_im = 64'(p_ri) + 64'(p_ir);
`ifdef FFT_BUTTERFLY_ROUND_EN
    sum_re = sum_re + (64'sd1 <<< (TWIDDLE_WIDTH - 2));
    sum_im = sum_im + (64'sd1 <<< (TWIDDLE_WIDTH - 2));
`endif
    sc_re = sum_re >>> (TWIDDLE_WIDTH - 1);
    sc_im = sum_im >>> (TWIDDLE_WIDTH - 1);
  end

  always_ff @(posedge clk_i) begin
    if (en) begin
      wb_re    <= (DATA_WIDTH + 1)'(sat_signed(sc_re, DATA_WIDTH + 1));
      wb_im    <= (DATA_WIDTH + 1)'(sat_signed(sc_im, DATA_WIDTH + 1));
      side_out <= side_s2;
    end
  end

endmodule

// File: rtl/fft_butterfly_unit.sv
// Radix-2 DIT butterfly X=A+W*B, Y=A-W*B with saturation; 4-cycle latency, 1 word/cycle.
// Global stall: all stages hold while out_valid_o=1 and out_ready_i=0 (in_ready_o drops).
// Build option FFT_BUTTERFLY_ROUND_EN: round-half-up on the twiddle product scale.
module fft_butterfly_unit
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH    = FFT_DW,
  parameter int TWIDDLE_WIDTH = FFT_TW
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [DATA_WIDTH-1:0]    a_real_i,
  input  logic [DATA_WIDTH-1:0]    a_imag_i,
  input  logic [DATA_WIDTH-1:0]    b_real_i,
  input  logic [DATA_WIDTH-1:0]    b_imag_i,
  input  logic [TWIDDLE_WIDTH-1:0] tw_real_i,
  input  logic [TWIDDLE_WIDTH-1:0] tw_imag_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [DATA_WIDTH-1:0]    x_real_o,
  output logic [DATA_WIDTH-1:0]    x_imag_o,
  output logic [DATA_WIDTH-1:0]    y_real_o,
  output logic [DATA_WIDTH-1:0]    y_imag_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     sat_o,
  output logic [7:0]               sat_count_o,
  input  logic                     clear_i,
  output logic                     busy_o
);

  logic                            adv, s1_vld, s2_vld, s3_vld;
  logic signed [DATA_WIDTH-1:0]    a_re1, a_im1, b_re1, b_im1;
  logic signed [TWIDDLE_WIDTH-1:0] w_re1, w_im1;
  logic signed [DATA_WIDTH:0]      wb_re, wb_im;
  logic [2*DATA_WIDTH-1:0]         a_s3;
  logic signed [DATA_WIDTH-1:0]    a_re3, a_im3;
  logic signed [63:0]              xr_sum, xi_sum, yr_sum, yi_sum;
  logic signed [DATA_WIDTH-1:0]    xr_d, xi_d, yr_d, yi_d;
  logic                            sat_d, sat_q;

  assign adv        = !out_valid_o || out_ready_i;
  assign in_ready_o = adv;
  assign busy_o     = s1_vld | s2_vld | s3_vld | out_valid_o;
  assign sat_o      = out_valid_o & sat_q;
  assign a_re3      = a_s3[2*DATA_WIDTH-1:DATA_WIDTH];
  assign a_im3      = a_s3[DATA_WIDTH-1:0];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_vld      <= 1'b0;
      out_valid_o <= 1'b0;
    end else if (adv) begin
      s1_vld      <= in_valid_i;
      out_valid_o <= s3_vld;
    end
  end

  always_ff @(posedge clk_i) begin
    if (adv) begin
      a_re1 <= a_real_i;
      a_im1 <= a_imag_i;
      b_re1 <= b_real_i;
      b_im1 <= b_imag_i;
      w_re1 <= tw_real_i;
      w_im1 <= tw_imag_i;
    end
  end

  // A rides through the multiplier stages as side-band so it lines up with W*B at S4.
  fft_cmult #(
    .DATA_WIDTH   (DATA_WIDTH),
    .TWIDDLE_WIDTH(TWIDDLE_WIDTH),
    .SIDE_WIDTH   (2 * DATA_WIDTH)
  ) u_cmult (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .en       (adv),
    .in_vld   (s1_vld),
    .b_re     (b_re1),
    .b_im     (b_im1),
    .w_re     (w_re1),
    .w_im     (w_im1),
    .side_in  ({a_re1, a_im1}),
    .s2_vld   (s2_vld),
    .s3_vld   (s3_vld),
    .wb_re    (wb_re),
    .wb_im    (wb_im),
    .side_out (a_s3)
  );

  always_comb begin
    xr_sum = 64'(a_re3) + 64'(wb_re);
    xi_sum = 64'(a_im3) + 64'(wb_im);
    yr_sum = 64'(a_re3) - 64'(wb_re);
    yi_sum = 64'(a_im3) - 64'(wb_im);
    xr_d   = DATA_WIDTH'(sat_signed(xr_sum, DATA_WIDTH));
    xi_d   = DATA_WIDTH'(sat_signed(xi_sum, DATA_WIDTH));
    yr_d   = DATA_WIDTH'(sat_signed(yr_sum, DATA_WIDTH));
    yi_d   = DATA_WIDTH'(sat_signed(yi_sum, DATA_WIDTH));
    sat_d  = (64'(xr_d) != xr_sum) | (64'(xi_d) != xi_sum) |
             (64'(yr_d) != yr_sum) | (64'(yi_d) != yi_sum);
  end

  always_ff @(posedge clk_i) begin
    if (adv) begin
      x_real_o <= xr_d;
      x_imag_o <= xi_d;
      y_real_o <= yr_d;
      y_imag_o <= yi_d;
      sat_q    <= sat_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sat_count_o <= 8'd0;
    end else if (clear_i) begin
      sat_count_o <= 8'd0;
    end else if (out_valid_o && out_ready_i && sat_o && (sat_count_o != 8'hFF)) begin
      sat_count_o <= sat_count_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_fft_butterfly_unit.sv
// Directed-vector bench for fft_butterfly_unit; expected words are queued at input
// transfer and checked in order by an independent output monitor.
module tb_fft_butterfly_unit;
  import fft_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [15:0] a_real_i, a_imag_i, b_real_i, b_imag_i, tw_real_i, tw_imag_i;
  logic        in_valid_i, in_ready_o;
  logic [15:0] x_real_o, x_imag_o, y_real_o, y_imag_o;
  logic        out_valid_o, out_ready_i, sat_o, clear_i, busy_o;
  logic [7:0]  sat_count_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    cplx_t x;
    cplx_t y;
    logic  sat;
    logic  lat;
    int    t0;
  } exp_t;

  exp_t q[$];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  fft_butterfly_unit dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .a_real_i   (a_real_i),
    .a_imag_i   (a_imag_i),
    .b_real_i   (b_real_i),
    .b_imag_i   (b_imag_i),
    .tw_real_i  (tw_real_i),
    .tw_imag_i  (tw_imag_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .x_real_o   (x_real_o),
    .x_imag_o   (x_imag_o),
    .y_real_o   (y_real_o),
    .y_imag_o   (y_imag_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .sat_o      (sat_o),
    .sat_count_o(sat_count_o),
    .clear_i    (clear_i),
    .busy_o     (busy_o)
  );

  function automatic cplx_t cx(input logic [15:0] r, input logic [15:0] i);
    cplx_t c;
    c.re = r;
    c.im = i;
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: an output transfer happens at the next rising edge when valid && ready.
  always @(negedge clk_i) begin
    exp_t e;
    if (reset_n_i && out_valid_o && out_ready_i) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got X=(%h,%h) Y=(%h,%h), required no output",
                 x_real_o, x_imag_o, y_real_o, y_imag_o);
      end else begin
        e = q.pop_front();
        total++;
        if (x_real_o !== e.x.re || x_imag_o !== e.x.im || y_real_o !== e.y.re ||
            y_imag_o !== e.y.im || sat_o !== e.sat) begin
          bad++;
          $display("FAIL word: got X=(%h,%h) Y=(%h,%h) sat=%b, required X=(%h,%h) Y=(%h,%h) sat=%b",
                   x_real_o, x_imag_o, y_real_o, y_imag_o, sat_o,
                   e.x.re, e.x.im, e.y.re, e.y.im, e.sat);
        end
        if (e.lat) check("latency", 64'(cyc - e.t0), 64'd4);
      end
    end
  end

  // Drives one operand set and holds it until accepted; leaves in_valid_i high.
  task automatic send(input cplx_t a, input cplx_t b, input cplx_t w, input cplx_t x,
                      input cplx_t y, input logic s, input logic lat, input logic push);
    exp_t e;
    int   n;
    n = 0;
    @(posedge clk_i); #1;
    a_real_i   = a.re;
    a_imag_i   = a.im;
    b_real_i   = b.re;
    b_imag_i   = b.im;
    tw_real_i  = w.re;
    tw_imag_i  = w.im;
    in_valid_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (in_ready_o) begin
        if (push) begin
          e.x = x; e.y = y; e.sat = s; e.lat = lat; e.t0 = cyc;
          q.push_back(e);
        end
        break;
      end
      n++;
      if (n > 100) begin
        total++;
        bad++;
        $display("FAIL send_timeout: in_ready_o=%b, required 1 within 100 cycles", in_ready_o);
        break;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", q.size());
      q.delete();
    end
    @(posedge clk_i); #1;
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!out_valid_o && n < 50);
    check("out_valid_wait", 64'(out_valid_o), 64'd1);
  endtask

  cplx_t       wmj, one;
  logic [15:0] sxr [8];
  logic [15:0] syr [8];

  initial begin
    int idx;
    wmj = cx(16'h0000, TW_MINUS_ONE);
    one = cx(TW_ONE, 16'h0000);
    sxr = '{16'h0000, 16'h0102, 16'h0204, 16'h0306, 16'h0408, 16'h050A, 16'h060C, 16'h070E};
    syr = '{16'h0000, 16'h00FE, 16'h01FC, 16'h02FA, 16'h03F8, 16'h04F6, 16'h05F4, 16'h06F2};

    reset_n_i  = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    clear_i    = 1'b0;
    a_real_i = '0; a_imag_i = '0; b_real_i = '0; b_imag_i = '0; tw_real_i = '0; tw_imag_i = '0;
    repeat (3) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    @(negedge clk_i);
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_sat_count", 64'(sat_count_o), 64'd0);
    check("rst_sat", 64'(sat_o), 64'd0);
    check("rst_in_ready", 64'(in_ready_o), 64'd1);

    // W = +1 on a value that exposes the rounding mode.
`ifdef FFT_BUTTERFLY_ROUND_EN
    send(cx(16'h1000, 0), cx(16'h0800, 0), one, cx(16'h1800, 0), cx(16'h0800, 0), 1'b0, 1'b1, 1'b1);
`else
    send(cx(16'h1000, 0), cx(16'h0800, 0), one, cx(16'h17FF, 0), cx(16'h0801, 0), 1'b0, 1'b1, 1'b1);
`endif
    drain();

    // W = -j: exact result, negative imaginary output.
    send(cx(0, 0), cx(16'h0100, 0), wmj, cx(0, 16'hFF00), cx(0, 16'h0100), 1'b0, 1'b1, 1'b1);
    drain();

    // Positive overflow on X.
    send(cx(16'h7000, 0), cx(16'h7000, 0), one, cx(16'h7FFF, 0), cx(16'h0001, 0), 1'b1, 1'b0, 1'b1);
    drain();
    @(negedge clk_i);
    check("sat_count_after_pos_sat", 64'(sat_count_o), 64'd1);

    // Negative overflow on Y.
    send(cx(16'h8000, 0), cx(0, 16'h0100), wmj, cx(16'h8100, 0), cx(16'h8000, 0), 1'b1, 1'b0, 1'b1);
    drain();
    @(negedge clk_i);
    check("sat_count_after_neg_sat", 64'(sat_count_o), 64'd2);

    // 8-word stream with downstream stalled for stream cycles 5..7.
    idx = 0;
    for (int s = 0; s < 16; s++) begin
      @(posedge clk_i); #1;
      out_ready_i = !(s >= 5 && s <= 7);
      if (idx < 8) begin
        a_real_i   = 16'(idx) << 8;
        a_imag_i   = 16'h0010;
        b_real_i   = 16'h0001;
        b_imag_i   = 16'(idx) << 1;
        tw_real_i  = wmj.re;
        tw_imag_i  = wmj.im;
        in_valid_i = 1'b1;
      end else begin
        in_valid_i = 1'b0;
      end
      @(negedge clk_i);
      check("stream_in_ready", 64'(in_ready_o), (s >= 5 && s <= 7) ? 64'd0 : 64'd1);
      if (in_valid_i && in_ready_o) begin
        q.push_back('{x: cx(sxr[idx], 16'h000F), y: cx(syr[idx], 16'h0011), sat: 1'b0, lat: 1'b0, t0: cyc});
        idx++;
      end
    end
    check("stream_words_sent", 64'(idx), 64'd8);
    drain();

    // Saturation counter sticks at 255.
    for (int k = 0; k < 300; k++) begin
      send(cx(16'h7000, 0), cx(16'h7000, 0), one, cx(16'h7FFF, 0), cx(16'h0001, 0), 1'b1, 1'b0, 1'b1);
    end
    drain();
    @(negedge clk_i);
    check("sat_count_sticky", 64'(sat_count_o), 64'd255);

    // Clear coinciding with a saturating transfer wins.
    out_ready_i = 1'b0;
    send(cx(16'h7000, 0), cx(16'h7000, 0), one, cx(16'h7FFF, 0), cx(16'h0001, 0), 1'b1, 1'b0, 1'b1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    wait_out_valid();
    check("stall_in_ready", 64'(in_ready_o), 64'd0);
    @(posedge clk_i); #1;
    out_ready_i = 1'b1;
    clear_i     = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    @(negedge clk_i);
    check("sat_count_clear", 64'(sat_count_o), 64'd0);
    check("clear_queue_empty", 64'(q.size()), 64'd0);

    // Reset with three words in flight, the oldest stalled at the output.
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send(cx(16'h0123, 0), cx(16'h0100, 0), wmj, cx(0, 0), cx(0, 0), 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    wait_out_valid();
    check("pre_reset_busy", 64'(busy_o), 64'd1);
    @(posedge clk_i); #1;
    reset_n_i = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_sat", 64'(sat_o), 64'd0);
    #20;
    reset_n_i   = 1'b1;
    out_ready_i = 1'b1;
    repeat (12) @(negedge clk_i);
    check("post_reset_out_valid", 64'(out_valid_o), 64'd0);
    check("post_reset_busy", 64'(busy_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
